dense_ctrl: RTL and testbench

Sequencer that runs one fully-connected (dense) layer on the PE array by generating the DENSE-mode control set consumed by `buffer_pea_mux` (comp_sel = 3'b010). It streams weights from banks 0..31 and the input vector from bank 32 of the source buffer. It then serialises the 32 latched neuron results into bank 32 of the destination buffer, group by group, until all outputs are produced. A layer-level scheduler drives `start`/`ping` and waits for `done`.

---
 rtl/dense_pkg.sv | 21 ++
 rtl/dense_ctrl_delay_line.sv | 32 +++
 rtl/dense_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_dense_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dense_pkg.sv
// Shared types and constants for the dense-layer sequencer.
package dense_pkg;

    typedef enum logic [2:0] {
        DS_IDLE,
        DS_CLEAR,
        DS_MAC,
        DS_DRAIN,
        DS_LATCH,
        DS_WRITE,
        DS_FIN
    } dense_state_e;

    localparam int unsigned DENSE_LANE    = 32;
    localparam int unsigned DENSE_IN_BANK = 32;

    // Operand routing codes for the PE array in dense mode
    localparam logic [1:0] MODE_AYBZ = 2'b11;
    localparam logic [1:0] MODE_AZBY = 2'b10;

endpackage

// File: rtl/dense_ctrl_delay_line.sv
// Fixed-depth pipeline delay with async reset to zero; depth 0 is a wire.
module delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] pipe [DEPTH];

            // Shift register stages
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < int'(DEPTH); i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= d;
                    for (int i = 1; i < int'(DEPTH); i++) pipe[i] <= pipe[i-1];
                end
            end

            assign q = pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/dense_ctrl.sv
// Dense-layer sequencer: streams weights/inputs into the PE array, then
// serialises latched neuron results into the destination buffer per group.
module dense_ctrl
    import dense_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned N_LANE = DENSE_LANE,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned WR_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       ping,
    input  logic [ADDR_W-1:0]          n_in,
    input  logic [ADDR_W-1:0]          n_out,
    input  logic [ADDR_W-1:0]          w_base,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 aybz_azby_dense,
    output logic                       buf1_r_en,
    output logic                       buf2_r_en,
    output logic [ADDR_W-1:0]          r_addr_w,
    output logic [ADDR_W-1:0]          r_addr_x,
    output logic [N_LANE:0]            buf1_w_en,
    output logic [N_LANE:0]            buf2_w_en,
    output logic [ADDR_W-1:0]          w_addr,
    output logic                       dense_enable,
    output logic                       dense_adder_reset,
    output logic                       dense_adder_on,
    output logic                       dense_latch,
    output logic                       dense_valid,
    output logic [$clog2(N_LANE)-1:0]  dense_rd_addr
);

    localparam int unsigned LANE_W = $clog2(N_LANE);

    dense_state_e state, state_n;

    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] n_in_q;
    logic [ADDR_W-1:0] n_out_q;
    logic [ADDR_W-1:0] obase;
    logic [ADDR_W-1:0] wrow;
    logic              ping_q;

    logic              accept;
    logic [ADDR_W-1:0] rem;
    logic [ADDR_W-1:0] grp_len;

    // Start acceptance and current-group length
    always_comb begin
        accept  = (state == DS_IDLE) && start;
        rem     = n_out_q - obase;
        grp_len = (rem > ADDR_W'(N_LANE)) ? ADDR_W'(N_LANE) : rem;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= DS_IDLE;
        else        state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            DS_IDLE: begin
                if (start) state_n = (n_in == '0 || n_out == '0) ? DS_FIN : DS_CLEAR;
            end
            DS_CLEAR: state_n = DS_MAC;
            DS_MAC: begin
                if (cnt == n_in_q - ADDR_W'(1)) state_n = DS_DRAIN;
            end
            DS_DRAIN: begin
                if (cnt == ADDR_W'(RD_LAT)) state_n = DS_LATCH;
            end
            DS_LATCH: state_n = DS_WRITE;
            DS_WRITE: begin
                if (cnt == grp_len + ADDR_W'(WR_LAT) - ADDR_W'(1))
                    state_n = (rem > ADDR_W'(N_LANE)) ? DS_CLEAR : DS_FIN;
            end
            DS_FIN:  state_n = DS_IDLE;
            default: state_n = DS_IDLE;
        endcase
    end

    // Layer parameters, per-state counter and per-group bases
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            n_in_q  <= '0;
            n_out_q <= '0;
            obase   <= '0;
            wrow    <= '0;
            ping_q  <= 1'b1;
        end else begin
            cnt <= (state_n != state) ? '0 : cnt + ADDR_W'(1);
            if (accept) begin
                n_in_q  <= n_in;
                n_out_q <= n_out;
                wrow    <= w_base;
                obase   <= '0;
                ping_q  <= ping;
            end else if (state == DS_WRITE && state_n == DS_CLEAR) begin
                obase <= obase + ADDR_W'(N_LANE);
                wrow  <= wrow + n_in_q;
            end
        end
    end

    logic              en_d;
    logic              areset_d;
    logic              mac_rd_d;
    logic [ADDR_W-1:0] raw_d;
    logic [ADDR_W-1:0] rax_d;
    logic              latch_d;
    logic              valid_d;
    logic [LANE_W-1:0] rda_d;
    logic [ADDR_W-1:0] wa_d;
    logic              done_d;
    logic [1:0]        mode_d;

    // Output decode from current state and counters
    always_comb begin
        en_d     = 1'b0;
        areset_d = 1'b0;
        mac_rd_d = 1'b0;
        raw_d    = '0;
        rax_d    = '0;
        latch_d  = 1'b0;
        valid_d  = 1'b0;
        rda_d    = '0;
        wa_d     = '0;
        done_d   = 1'b0;
        mode_d   = ping_q ? MODE_AYBZ : MODE_AZBY;
        unique case (state)
            DS_IDLE:  areset_d = 1'b1;
            DS_CLEAR: begin
                en_d     = 1'b1;
                areset_d = 1'b1;
            end
            DS_MAC: begin
                en_d     = 1'b1;
                mac_rd_d = 1'b1;
                raw_d    = wrow + cnt;
                rax_d    = cnt;
            end
            DS_DRAIN: en_d = 1'b1;
            DS_LATCH: begin
                en_d    = 1'b1;
                latch_d = 1'b1;
            end
            DS_WRITE: begin
                en_d = 1'b1;
                if (cnt < grp_len) begin
                    valid_d = 1'b1;
                    rda_d   = cnt[LANE_W-1:0];
                    wa_d    = obase + cnt;
                end
            end
            DS_FIN: begin
                en_d   = 1'b1;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    logic              mac_rd_q;
    logic              w1_q;
    logic              w2_q;
    logic [ADDR_W-1:0] wa_q;

    // Registered outputs; busy spans accept up to (not including) done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy              <= 1'b0;
            done              <= 1'b0;
            aybz_azby_dense   <= MODE_AYBZ;
            buf1_r_en         <= 1'b0;
            buf2_r_en         <= 1'b0;
            r_addr_w          <= '0;
            r_addr_x          <= '0;
            dense_enable      <= 1'b0;
            dense_adder_reset <= 1'b1;
            dense_latch       <= 1'b0;
            dense_valid       <= 1'b0;
            dense_rd_addr     <= '0;
            mac_rd_q          <= 1'b0;
            w1_q              <= 1'b0;
            w2_q              <= 1'b0;
            wa_q              <= '0;
        end else begin
            if (accept)               busy <= 1'b1;
            else if (state == DS_FIN) busy <= 1'b0;
            done              <= done_d;
            aybz_azby_dense   <= mode_d;
            buf1_r_en         <= mac_rd_d & ping_q;
            buf2_r_en         <= mac_rd_d & ~ping_q;
            r_addr_w          <= raw_d;
            r_addr_x          <= rax_d;
            dense_enable      <= en_d;
            dense_adder_reset <= areset_d;
            dense_latch       <= latch_d;
            dense_valid       <= valid_d;
            dense_rd_addr     <= rda_d;
            mac_rd_q          <= mac_rd_d;
            w1_q              <= valid_d & ~ping_q;
            w2_q              <= valid_d & ping_q;
            wa_q              <= wa_d;
        end
    end

    // Accumulator enable follows the MAC reads by the buffer read latency
    delay_line #(.DEPTH(RD_LAT), .WIDTH(1)) u_aon_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (mac_rd_q),
        .q     (dense_adder_on)
    );

    logic              w1_dly;
    logic              w2_dly;
    logic [ADDR_W-1:0] wa_dly;

    // Write enable and address follow dense_valid by the lane-output latency
    delay_line #(.DEPTH(WR_LAT), .WIDTH(ADDR_W + 2)) u_wr_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({w1_q, w2_q, wa_q}),
        .q     ({w1_dly, w2_dly, wa_dly})
    );

    // Only the input-vector bank of the destination buffer is written
    assign buf1_w_en = {w1_dly, {N_LANE{1'b0}}};
    assign buf2_w_en = {w2_dly, {N_LANE{1'b0}}};
    assign w_addr    = wa_dly;

endmodule

// File: tb/tb_dense_ctrl.sv
// Directed plus randomized layer runs checked against a transaction-level model.
module tb_dense_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        ping;
    logic [15:0] n_in;
    logic [15:0] n_out;
    logic [15:0] w_base;
    logic        busy;
    logic        done;
    logic [1:0]  aybz_azby_dense;
    logic        buf1_r_en;
    logic        buf2_r_en;
    logic [15:0] r_addr_w;
    logic [15:0] r_addr_x;
    logic [32:0] buf1_w_en;
    logic [32:0] buf2_w_en;
    logic [15:0] w_addr;
    logic        dense_enable;
    logic        dense_adder_reset;
    logic        dense_adder_on;
    logic        dense_latch;
    logic        dense_valid;
    logic [4:0]  dense_rd_addr;

    int checks = 0;
    int errors = 0;

    localparam int RD_LAT = 1;
    localparam int WR_LAT = 1;

    dense_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .ping              (ping),
        .n_in              (n_in),
        .n_out             (n_out),
        .w_base            (w_base),
        .busy              (busy),
        .done              (done),
        .aybz_azby_dense   (aybz_azby_dense),
        .buf1_r_en         (buf1_r_en),
        .buf2_r_en         (buf2_r_en),
        .r_addr_w          (r_addr_w),
        .r_addr_x          (r_addr_x),
        .buf1_w_en         (buf1_w_en),
        .buf2_w_en         (buf2_w_en),
        .w_addr            (w_addr),
        .dense_enable      (dense_enable),
        .dense_adder_reset (dense_adder_reset),
        .dense_adder_on    (dense_adder_on),
        .dense_latch       (dense_latch),
        .dense_valid       (dense_valid),
        .dense_rd_addr     (dense_rd_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".buf1_r_en"}, 64'(buf1_r_en), 64'd0);
        chk({tag, ".buf2_r_en"}, 64'(buf2_r_en), 64'd0);
        chk({tag, ".buf1_w_en"}, 64'(buf1_w_en), 64'd0);
        chk({tag, ".buf2_w_en"}, 64'(buf2_w_en), 64'd0);
        chk({tag, ".r_addr_w"}, 64'(r_addr_w), 64'd0);
        chk({tag, ".r_addr_x"}, 64'(r_addr_x), 64'd0);
        chk({tag, ".w_addr"}, 64'(w_addr), 64'd0);
        chk({tag, ".enable"}, 64'(dense_enable), 64'd0);
        chk({tag, ".adder_reset"}, 64'(dense_adder_reset), 64'd1);
        chk({tag, ".adder_on"}, 64'(dense_adder_on), 64'd0);
        chk({tag, ".latch"}, 64'(dense_latch), 64'd0);
        chk({tag, ".valid"}, 64'(dense_valid), 64'd0);
        chk({tag, ".rd_addr"}, 64'(dense_rd_addr), 64'd0);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".done"}, 64'(done), 64'd0);
        chk({tag, ".mode"}, 64'(aybz_azby_dense), 64'h3);
    endtask

    // One layer: build the expected transaction lists, run, compare.
    task automatic run_layer(input string name, input logic p, input int ni, input int no,
                             input int wb, input int inj);
        int e_rw[$], e_rx[$], e_wa[$];
        int q_rw[$], q_rx[$], q_wa[$];
        int groups, exp_done, len, cyc, done_cyc, done_n, busy_n, aon_n, latch_n, viol, vcount;
        logic prev_ren, prev_val, srcr, othr;
        logic [32:0] dstw, othw;
        logic [1:0] mode_at_done;

        groups   = (ni == 0 || no == 0) ? 0 : (no + 31) / 32;
        exp_done = 2;
        for (int g = 0; g < groups; g++) begin
            len = (no - 32 * g > 32) ? 32 : no - 32 * g;
            exp_done += 1 + ni + (RD_LAT + 1) + 1 + len + WR_LAT;
            for (int k = 0; k < ni; k++) begin
                e_rw.push_back((wb + g * ni + k) & 32'hFFFF);
                e_rx.push_back(k);
            end
            for (int i = 0; i < len; i++) e_wa.push_back(32 * g + i);
        end

        @(negedge clk);
        start  = 1'b1;
        ping   = p;
        n_in   = 16'(ni);
        n_out  = 16'(no);
        w_base = 16'(wb);

        prev_ren = 1'b0; prev_val = 1'b0; mode_at_done = 2'b00;
        done_cyc = -1; done_n = 0; busy_n = 0; aon_n = 0; latch_n = 0; viol = 0; vcount = 0;
        cyc = 1;
        while (cyc <= exp_done + 20) begin
            @(negedge clk);
            srcr = p ? buf1_r_en : buf2_r_en;
            othr = p ? buf2_r_en : buf1_r_en;
            dstw = p ? buf2_w_en : buf1_w_en;
            othw = p ? buf1_w_en : buf2_w_en;
            if (othr || othw != '0 || dstw[31:0] != '0) viol++;
            if (srcr) begin
                q_rw.push_back(int'(r_addr_w));
                q_rx.push_back(int'(r_addr_x));
            end
            if (dstw[32]) q_wa.push_back(int'(w_addr));
            if (dense_adder_on !== prev_ren) viol++;
            if (dstw[32] !== prev_val) viol++;
            if (dense_valid) begin
                if (dense_rd_addr !== 5'(vcount % 32)) viol++;
                vcount++;
            end
            aon_n   += int'(dense_adder_on);
            latch_n += int'(dense_latch);
            busy_n  += int'(busy);
            if (done) begin
                done_n++;
                if (done_cyc < 0) begin
                    done_cyc     = cyc;
                    mode_at_done = aybz_azby_dense;
                end
            end
            prev_ren = buf1_r_en | buf2_r_en;
            prev_val = dense_valid;
            if (cyc == 1) begin
                start  = 1'b0;
                ping   = 1'($urandom);
                n_in   = 16'($urandom);
                n_out  = 16'($urandom);
                w_base = 16'($urandom);
            end
            if (inj != 0 && cyc == inj) begin
                start = 1'b1;
                n_out = 16'(no + 33);
            end
            if (inj != 0 && cyc == inj + 1) start = 1'b0;
            if (done_cyc > 0 && cyc == done_cyc + 2) break;
            cyc++;
        end

        chk({name, ".done_seen"}, 64'(done_cyc > 0), 64'd1);
        chk({name, ".done_cycle"}, 64'(done_cyc), 64'(exp_done));
        chk({name, ".done_pulses"}, 64'(done_n), 64'd1);
        chk({name, ".busy_cycles"}, 64'(busy_n), 64'(exp_done - 1));
        chk({name, ".mode"}, 64'(mode_at_done), p ? 64'h3 : 64'h2);
        chk({name, ".adder_on_cycles"}, 64'(aon_n), 64'(ni * groups));
        chk({name, ".latch_cycles"}, 64'(latch_n), 64'(groups));
        chk({name, ".violations"}, 64'(viol), 64'd0);
        chk({name, ".idle_enable"}, 64'(dense_enable), 64'd0);
        chk({name, ".idle_adder_reset"}, 64'(dense_adder_reset), 64'd1);
        chk({name, ".reads"}, 64'(q_rw.size()), 64'(e_rw.size()));
        chk({name, ".writes"}, 64'(q_wa.size()), 64'(e_wa.size()));
        for (int i = 0; i < e_rw.size() && i < q_rw.size(); i++) begin
            chk($sformatf("%s.r_addr_w[%0d]", name, i), 64'(q_rw[i]), 64'(e_rw[i]));
            chk($sformatf("%s.r_addr_x[%0d]", name, i), 64'(q_rx[i]), 64'(e_rx[i]));
        end
        for (int i = 0; i < e_wa.size() && i < q_wa.size(); i++)
            chk($sformatf("%s.w_addr[%0d]", name, i), 64'(q_wa[i]), 64'(e_wa[i]));
    endtask

    initial begin
        logic seen;
        int   ni, no, wb, inj;
        logic p;

        rst_n = 1'b0; start = 1'b0; ping = 1'b0;
        n_in = '0; n_out = '0; w_base = '0;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_layer("single", 1'b1, 4, 5, 16'h10, 0);
        run_layer("multi", 1'b0, 3, 70, 16'h200, 0);
        run_layer("empty_in", 1'b1, 0, 10, 16'h5, 0);
        run_layer("empty_out", 1'b0, 5, 0, 16'h5, 0);
        run_layer("ignored_start", 1'b1, 5, 40, 16'h30, 3);
        run_layer("wrap", 1'b0, 4, 8, 16'hFFFE, 0);

        // Reset asserted while results are being written out
        @(negedge clk);
        start = 1'b1; ping = 1'b1; n_in = 16'd2; n_out = 16'd40; w_base = 16'd5;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (dense_valid) seen = 1'b1;
        end
        chk("rst_mid.valid_seen", 64'(seen), 64'd1);
        chk("rst_mid.busy_before", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_reset("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        run_layer("after_reset", 1'b0, 3, 33, 16'h100, 0);

        for (int r = 0; r < 6; r++) begin
            ni  = int'($urandom_range(1, 6));
            no  = int'($urandom_range(1, 100));
            wb  = int'($urandom_range(0, 65535));
            p   = 1'($urandom);
            inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, ni + 1)) : 0;
            run_layer($sformatf("rand%0d", r), p, ni, no, wb, inj);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
